// File: rtl/usrt_shift_core.sv
// rtl/usrt_shift_core.sv - byte-serial TX/RX shifter pair (8N1, programmable bit period)
module usrt_shift_core #(
    parameter int BAUD_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Presetn,
    input  logic [BAUD_W-1:0] i_Baud,
    input  logic              i_Tx_Enable,
    input  logic [DATA_W-1:0] i_Tx_Data,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Pready,
    input  logic              i_Rx_Enable,
    input  logic              i_Rx_Serial,
    output logic [DATA_W-1:0] o_Rx_Data,
    output logic              o_Rx_Done
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] CNT_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE, RX_WAIT_HIGH} rx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d, tx_baud_q, tx_baud_d;
    logic [IDX_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_last;

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_last = (tx_cnt_q == tx_baud_q - CNT_ONE);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_baud_d   = tx_baud_q;
        tx_bit_d    = tx_bit_q;
        tx_data_d   = tx_data_q;
        o_Tx_Serial = 1'b1;
        o_Tx_Pready = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (i_Tx_Enable) begin
                    tx_data_d  = i_Tx_Data;
                    tx_baud_d  = i_Baud;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                o_Tx_Serial = 1'b0;
                tx_cnt_d    = tx_last ? '0 : tx_cnt_q + CNT_ONE;
                if (tx_last) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                o_Tx_Serial = tx_data_q[tx_bit_q];
                tx_cnt_d    = tx_last ? '0 : tx_cnt_q + CNT_ONE;
                if (tx_last) begin
                    if (tx_bit_q == IDX_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + IDX_W'(1);
                    end
                end
            end
            TX_STOP: begin
                tx_cnt_d = tx_last ? '0 : tx_cnt_q + CNT_ONE;
                if (tx_last) tx_state_d = TX_DONE;
            end
            TX_DONE: begin
                o_Tx_Pready = 1'b1;
                tx_state_d  = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    logic rx_meta_q, rx_sync_q;
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d, rx_baud_q, rx_baud_d;
    logic [IDX_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic              rx_last, rx_half_last;

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign rx_last      = (rx_cnt_q == rx_baud_q - CNT_ONE);
    assign rx_half_last = (rx_cnt_q == (rx_baud_q >> 1) - CNT_ONE);
    assign o_Rx_Data    = rx_data_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        o_Rx_Done  = 1'b0;
        if (!i_Rx_Enable) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_baud_d  = i_Baud;
                        rx_cnt_d   = '0;
                        rx_state_d = RX_START;
                    end
                end
                // Re-check at mid start bit; a high line here means a glitch.
                RX_START: begin
                    rx_cnt_d = rx_half_last ? '0 : rx_cnt_q + CNT_ONE;
                    if (rx_half_last) begin
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_cnt_d = rx_last ? '0 : rx_cnt_q + CNT_ONE;
                    if (rx_last) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q == IDX_LAST) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + IDX_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    rx_cnt_d = rx_last ? '0 : rx_cnt_q + CNT_ONE;
                    if (rx_last) begin
                        if (rx_sync_q) begin
                            rx_data_d  = rx_shift_q;
                            rx_state_d = RX_DONE;
                        end else begin
                            rx_state_d = RX_WAIT_HIGH;
                        end
                    end
                end
                RX_DONE: begin
                    o_Rx_Done  = 1'b1;
                    rx_state_d = RX_IDLE;
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_q) rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usrt_shift_core.sv
// tb/tb_usrt_shift_core.sv - self-checking bench for usrt_shift_core
module tb_usrt_shift_core;
    logic        i_Pclk = 1'b0;
    logic        i_Presetn;
    logic [13:0] i_Baud;
    logic        i_Tx_Enable;
    logic [7:0]  i_Tx_Data;
    logic        o_Tx_Serial;
    logic        o_Tx_Pready;
    logic        i_Rx_Enable;
    logic        i_Rx_Serial;
    logic [7:0]  o_Rx_Data;
    logic        o_Rx_Done;

    logic        loop_sel;
    logic        rx_drive;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pready = 0;
    int          exp_pready = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_rx[$];

    usrt_shift_core #(.BAUD_W(14), .DATA_W(8)) dut (
        .i_Pclk      (i_Pclk),
        .i_Presetn   (i_Presetn),
        .i_Baud      (i_Baud),
        .i_Tx_Enable (i_Tx_Enable),
        .i_Tx_Data   (i_Tx_Data),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Pready (o_Tx_Pready),
        .i_Rx_Enable (i_Rx_Enable),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_Data   (o_Rx_Data),
        .o_Rx_Done   (o_Rx_Done)
    );

    assign i_Rx_Serial = loop_sel ? o_Tx_Serial : rx_drive;

    always #5 i_Pclk = ~i_Pclk;

    always @(negedge i_Pclk) begin
        if (o_Tx_Pready) n_pready++;
        if (o_Rx_Done) rx_q.push_back(o_Rx_Data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for cycle k of a frame is bit floor(k/b) of {stop, data, start}.
    task automatic run_frame(input logic [7:0] d, input int b, input int lead, input bit keep);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        i_Tx_Data   = d;
        i_Baud      = 14'(b);
        i_Tx_Enable = 1'b1;
        for (int j = 0; j < lead; j++) begin
            @(negedge i_Pclk);
            chk("tx_gap_idle", o_Tx_Serial, 1);
        end
        for (int k = 0; k < 10 * b; k++) begin
            @(negedge i_Pclk);
            chk("tx_line", o_Tx_Serial, fr[k / b]);
            if (k == b) i_Baud = 14'($urandom_range(4, 200));
        end
        @(negedge i_Pclk);
        chk("tx_pready_at_10b", o_Tx_Pready, 1);
        exp_pready++;
        exp_rx.push_back(d);
        if (!keep) i_Tx_Enable = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] d, input int b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = fr[k];
            repeat (b) @(negedge i_Pclk);
        end
        rx_drive = 1'b1;
    endtask

    task automatic check_rx();
        chk("rx_count", rx_q.size(), exp_rx.size());
        while (rx_q.size() > 0 && exp_rx.size() > 0)
            chk("rx_byte", rx_q.pop_front(), exp_rx.pop_front());
        rx_q.delete();
        exp_rx.delete();
    endtask

    initial begin
        int          b;
        logic [7:0]  d;
        int          snap_p;
        i_Presetn   = 1'b0;
        i_Baud      = 14'd87;
        i_Tx_Enable = 1'b0;
        i_Tx_Data   = 8'h00;
        i_Rx_Enable = 1'b1;
        loop_sel    = 1'b1;
        rx_drive    = 1'b1;
        repeat (3) @(negedge i_Pclk);
        chk("reset_tx_serial", o_Tx_Serial, 1);
        chk("reset_tx_pready", o_Tx_Pready, 0);
        chk("reset_rx_data", o_Rx_Data, 0);
        chk("reset_rx_done", o_Rx_Done, 0);
        i_Presetn = 1'b1;
        repeat (5) @(negedge i_Pclk);

        // Loopback 0x53: Done must already have happened when Pready shows.
        run_frame(8'h53, 87, 0, 1'b0);
        chk("t1_done_before_pready", rx_q.size(), 1);
        repeat (200) @(negedge i_Pclk);
        chk("t1_pready_count", n_pready, exp_pready);
        check_rx();

        // Enable held high across two frames.
        run_frame(8'hA5, 87, 0, 1'b1);
        run_frame(8'h3C, 87, 1, 1'b0);
        repeat (200) @(negedge i_Pclk);
        chk("t2_pready_count", n_pready, exp_pready);
        chk("t2_rx_data", o_Rx_Data, 8'h3C);
        check_rx();

        // Start-bit glitch shorter than half a bit, then a valid 0x00.
        loop_sel = 1'b0;
        i_Baud   = 14'd87;
        rx_drive = 1'b0;
        repeat (20) @(negedge i_Pclk);
        rx_drive = 1'b1;
        repeat (200) @(negedge i_Pclk);
        chk("t3_glitch_no_done", rx_q.size(), 0);
        drive_rx(8'h00, 87, 1'b1);
        exp_rx.push_back(8'h00);
        repeat (100) @(negedge i_Pclk);
        chk("t3_rx_data", o_Rx_Data, 8'h00);
        check_rx();

        // Good 0x5A then 0xFF with a low stop bit: data must stay 0x5A.
        drive_rx(8'h5A, 87, 1'b1);
        exp_rx.push_back(8'h5A);
        repeat (50) @(negedge i_Pclk);
        drive_rx(8'hFF, 87, 1'b0);
        repeat (200) @(negedge i_Pclk);
        chk("t4_rx_data_kept", o_Rx_Data, 8'h5A);
        check_rx();
        drive_rx(8'hC3, 87, 1'b1);
        exp_rx.push_back(8'hC3);
        repeat (100) @(negedge i_Pclk);
        check_rx();

        // Asynchronous reset in the middle of a data bit.
        loop_sel    = 1'b1;
        i_Baud      = 14'd87;
        i_Tx_Data   = 8'h53;
        i_Tx_Enable = 1'b1;
        repeat (87 * 3 + 40) @(negedge i_Pclk);
        i_Tx_Enable = 1'b0;
        snap_p = n_pready;
        #3 i_Presetn = 1'b0;
        #1;
        chk("t5_rst_tx_serial", o_Tx_Serial, 1);
        chk("t5_rst_tx_pready", o_Tx_Pready, 0);
        chk("t5_rst_rx_done", o_Rx_Done, 0);
        chk("t5_rst_rx_data", o_Rx_Data, 0);
        @(negedge i_Pclk);
        i_Presetn = 1'b1;
        repeat (1500) @(negedge i_Pclk);
        chk("t5_no_pready_after", n_pready, snap_p);
        chk("t5_no_done_after", rx_q.size(), 0);
        chk("t5_line_idle", o_Tx_Serial, 1);

        // Minimum bit period.
        run_frame(8'h81, 4, 0, 1'b0);
        repeat (30) @(negedge i_Pclk);
        check_rx();

        // Randomised loopback frames with random bit periods.
        for (int i = 0; i < 6; i++) begin
            b = $urandom_range(8, 60);
            d = 8'($urandom);
            run_frame(d, b, 0, 1'b0);
            repeat (2 * b) @(negedge i_Pclk);
            check_rx();
        end
        chk("final_pready_count", n_pready, exp_pready);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usrt_shift_core.md
Name: usrt_shift_core

Overview:
- Byte-serial transmit and receive shifter pair sharing one peripheral clock and one programmable bit period.
- Format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
- The transmit half serialises a byte on request and flags completion. The receive half detects, samples and deserialises a frame and flags a valid byte.
- Sits between a register/APB front end and the external serial pins; TX output may be looped back to RX.

Parameters:
- BAUD_W, 14, width of the bit-period input.
- DATA_W, 8, data bits per frame. Only 8 is required to be supported.

Ports:
- i_Pclk  in  1  peripheral clock; all logic rising-edge.
- i_Presetn  in  1  asynchronous active-low reset.
- i_Baud  in  BAUD_W  bit period in i_Pclk cycles; legal range 4..16383.
- i_Tx_Enable  in  1  transmit request/enable.
- i_Tx_Data  in  DATA_W  byte to transmit; sampled at frame start.
- o_Tx_Serial  out  1  serial output; idle high.
- o_Tx_Pready  out  1  one-cycle pulse when a frame has fully left.
- i_Rx_Enable  in  1  receiver enable.
- i_Rx_Serial  in  1  asynchronous serial input.
- o_Rx_Data  out  DATA_W  last correctly received byte.
- o_Rx_Done  out  1  one-cycle pulse when o_Rx_Data is updated.

Behaviour:

Reset (async, i_Presetn=0):
- o_Tx_Serial=1, o_Tx_Pready=0, o_Rx_Data=0, o_Rx_Done=0.
- Both FSMs go to IDLE; counters are cleared; RX synchroniser flops are set to 1.
- Reset mid-frame aborts immediately; no pulse is emitted.

Bit timing:
- i_Baud is latched at frame start by each side; changes mid-frame have no effect until the next frame.

TX FSM (IDLE, START, DATA, STOP, DONE):
- IDLE: o_Tx_Serial=1. If i_Tx_Enable=1 at an edge, latch i_Tx_Data and i_Baud and go to START.
- START: drive 0 for i_Baud cycles.
- DATA: drive latched bit 0..7, each for i_Baud cycles.
- STOP: drive 1 for i_Baud cycles.
- DONE: one cycle, o_Tx_Pready=1, o_Tx_Serial=1, then IDLE.
- Frame length is exactly 10*i_Baud cycles. o_Tx_Pready rises at the edge following the last stop-bit cycle.
- If i_Tx_Enable is still high in IDLE after DONE, a new frame starts. A requester that drops enable on the edge of Pready gets exactly one frame.
- i_Tx_Enable dropping mid-frame does not abort the frame.

RX:
- i_Rx_Serial passes through a 2-flop synchroniser; all references below are to the synchronised signal.
- i_Rx_Enable=0 forces IDLE and holds o_Rx_Done=0; o_Rx_Data is retained.

RX FSM (IDLE, START, DATA, STOP, DONE):
- IDLE: on sampled 0 with i_Rx_Enable=1, latch i_Baud and go to START.
- START: wait floor(i_Baud/2) cycles, then re-sample. If 0, go to DATA with the counter reset. If 1 (glitch), return to IDLE.
- DATA: sample every i_Baud cycles (mid-bit); shift in LSB first, 8 samples.
- STOP: sample after i_Baud cycles.
  - If 1: load o_Rx_Data and pulse o_Rx_Done for one cycle (DONE), then IDLE.
  - If 0 (framing error): discard the byte, no Done, o_Rx_Data unchanged; wait for the line to return high before re-arming.
- Receiver returns to IDLE at mid-stop-bit, so back-to-back frames are received.
- A new start edge is accepted the cycle after DONE.

Test Plan:
1. Loopback, i_Baud=87, reset released, i_Tx_Enable=1 with i_Tx_Data=0x53, enable dropped on Pready -> o_Tx_Serial gives 0,1,1,0,0,1,0,1,0,1, each 87 cycles; single o_Tx_Pready pulse 870 cycles after start; single o_Rx_Done pulse with o_Rx_Data=0x53 before Pready.
2. Enable held high with data 0xA5 then 0x3C -> two consecutive frames, two Pready and two Done pulses; RX reads 0xA5 then 0x3C.
3. RX glitch: i_Rx_Serial low for 20 cycles at i_Baud=87 -> no o_Rx_Done; RX back in IDLE; next valid frame 0x00 is received.
4. Framing error: frame 0xFF with stop bit forced 0 -> no o_Rx_Done; o_Rx_Data keeps its prior value.
5. i_Presetn pulsed low mid-data-bit -> o_Tx_Serial=1 and all pulses 0 immediately; no pulses afterwards until a new request.
6. i_Baud=4, byte 0x81 loopback -> correct reception; frame length 40 cycles.
